// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches and buffers returned words,
// with their PCs, in an in-order queue presented to the decoder over valid/ready.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] instruction,
   output logic [31:0] inst_pc,
   output logic        protocol_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   // Back-to-back redirects with traffic in flight can stack discards beyond DEPTH.
   localparam int unsigned DW = 16;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } entry_t;

   entry_t          q_mem [DEPTH];
   entry_t          head;
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count, outstanding;
   logic [DW-1:0]   discard;
   logic [31:0]     fetch_pc, rsp_pc, target;
   logic [CW:0]     inflight;
   logic            accept, pop, rsp_take, rsp_err;

   assign inflight = {1'b0, count} + {1'b0, outstanding};
   assign mem_req  = !reset && !redirect && (inflight < DEPTH_C);
   assign mem_addr = fetch_pc;
   assign accept   = mem_req && mem_gnt;

   assign inst_valid  = (count != '0);
   assign pop         = inst_valid && inst_ready;
   assign head        = q_mem[rd_ptr];
   assign instruction = inst_valid ? head.word : 32'h0;
   assign inst_pc     = inst_valid ? head.pc   : 32'h0;

   // A response with neither a discard pending nor a fetch outstanding has no owner.
   assign rsp_err  = mem_rvalid && (discard == '0) && (outstanding == '0);
   assign rsp_take = mem_rvalid && !redirect && (discard == '0) && (outstanding != '0);
   assign target   = {redirect_pc[31:2], 2'b00};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc     <= RESET_PC;
         rsp_pc       <= RESET_PC;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         outstanding  <= '0;
         discard      <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (rsp_err)
            protocol_err <= 1'b1;
         if (redirect) begin
            fetch_pc    <= target;
            rsp_pc      <= target;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            // Everything still in flight becomes stale; a word arriving now is dropped here.
            discard     <= discard + DW'(outstanding) - DW'(mem_rvalid && !rsp_err);
         end else begin
            if (accept)
               fetch_pc <= fetch_pc + 32'd4;
            if (mem_rvalid && (discard != '0))
               discard <= discard - DW'(1);
            if (rsp_take) begin
               wr_ptr <= wr_ptr + AW'(1);
               rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            count       <= count + CW'(rsp_take) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(rsp_take);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rsp_take)
         q_mem[wr_ptr] <= '{word: mem_rdata, pc: rsp_pc};
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: in-order memory model with variable latency, epoch-based
// reference of the delivered instruction stream, and a negedge monitor checking every cycle.
module tb_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] instruction;
   logic [31:0] inst_pc;
   logic        protocol_err;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .instruction(instruction), .inst_pc(inst_pc), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } exp_t;

   mreq_t mem_q[$];   // requests accepted by the memory, in order
   exp_t  pend[$];    // current-epoch fetches not yet returned
   exp_t  sb[$];      // words the decoder should see, in order

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          rsp_epoch = 0;
   logic        rsp_bogus = 1'b0;
   logic        inject_bogus = 1'b0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   logic [31:0] model_pc = RESET_PC;
   logic        exp_perr = 1'b0;

   function automatic logic [31:0] image(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Memory: in-order, at most one response per cycle, each at least one cycle after its grant.
   always begin
      @(posedge clk);
      #1;
      cyc++;
      mem_rvalid = 1'b0;
      rsp_bogus  = 1'b0;
      if (reset) begin
         mem_q.delete();
      end else if (inject_bogus && mem_q.size() == 0) begin
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         rsp_bogus  = 1'b1;
      end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         mreq_t m;
         m = mem_q.pop_front();
         mem_rvalid = 1'b1;
         mem_rdata  = image(m.addr);
         rsp_epoch  = m.epoch;
      end
   end

   // Monitor/reference: looks at the settled pre-edge values and predicts the coming edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      int   exp_out;
      if (reset) begin
         chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
         chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
         chk("rst_instruction", instruction, 32'd0);
         chk("rst_inst_pc", inst_pc, 32'd0);
         chk("rst_protocol_err", {31'b0, protocol_err}, 32'd0);
         sb.delete();
         pend.delete();
         epoch++;
         model_pc = RESET_PC;
         exp_perr = 1'b0;
      end else begin
         chk("protocol_err", {31'b0, protocol_err}, {31'b0, exp_perr});
         chk("inst_valid", {31'b0, inst_valid}, {31'b0, sb.size() != 0});
         if (sb.size() == 0) begin
            chk("empty_instruction", instruction, 32'd0);
            chk("empty_inst_pc", inst_pc, 32'd0);
         end
         exp_out = pend.size();
         chk("mem_req", {31'b0, mem_req},
             {31'b0, !redirect && (sb.size() + exp_out < DEPTH)});

         if (mem_req && mem_gnt) begin
            chk("mem_addr", mem_addr, model_pc);
            mem_q.push_back('{addr: mem_addr, epoch: epoch,
                              due: cyc + $urandom_range(lat_hi, lat_lo)});
            pend.push_back('{pc: model_pc, word: image(model_pc)});
            model_pc = model_pc + 32'd4;
         end

         if (inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
               chk("pop_nonempty", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("inst_pc", inst_pc, e.pc);
               chk("instruction", instruction, e.word);
            end
         end

         if (mem_rvalid) begin
            if (rsp_bogus)
               exp_perr = 1'b1;
            else if (!redirect && rsp_epoch == epoch && pend.size() != 0)
               sb.push_back(pend.pop_front());
         end

         if (redirect) begin
            sb.delete();
            pend.delete();
            epoch++;
            model_pc = {redirect_pc[31:2], 2'b00};
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin : driver
      int sel;
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      mem_gnt     = 1'b0;
      inst_ready  = 1'b0;
      step(3);
      reset = 1'b0;

      // Streaming with a 1-cycle memory.
      mem_gnt = 1'b1; inst_ready = 1'b1;
      step(40);

      // Decoder stalls: queue fills, fetch stops, then drains and resumes.
      inst_ready = 1'b0;
      step(20);
      inst_ready = 1'b1;
      step(10);

      // Redirect with several fetches in flight on a 3-cycle memory.
      lat_lo = 3; lat_hi = 3;
      step(6);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      step(1);
      redirect = 1'b0;
      step(20);

      // Address wrap past the top of the address space.
      lat_lo = 1; lat_hi = 1;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      step(1);
      redirect = 1'b0;
      step(12);

      // Randomized traffic, latencies and redirects.
      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         mem_gnt    = ($urandom_range(9, 0) < 7);
         inst_ready = ($urandom_range(9, 0) < 6);
         redirect   = ($urandom_range(19, 0) == 0);
         sel = $urandom_range(3, 0);
         case (sel)
            0: redirect_pc = $urandom;
            1: redirect_pc = 32'hFFFF_FFF8;
            2: redirect_pc = 32'h0000_0103;
            default: redirect_pc = $urandom & 32'h0000_0FFF;
         endcase
         step(1);
      end
      redirect = 1'b0;

      // Stray response with nothing outstanding: sticky error, queue untouched.
      mem_gnt = 1'b0; inst_ready = 1'b1;
      step(12);
      inject_bogus = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inject_bogus = 1'b0;
      step(3);
      mem_gnt = 1'b1;
      step(10);

      // Asynchronous reset in the middle of a burst.
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("async_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("async_rst_protocol_err", {31'b0, protocol_err}, 32'd0);
      step(2);
      reset = 1'b0;
      step(20);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
